// File: rtl/cp0_core_param_if.sv
// rtl/cp0_core_param_if.sv - CP0 register/exception bus between the pipeline and cp0_core_param
interface cp0_core_param_if #(
  parameter int unsigned NUM_HW_INT = 6
);
  logic                  we;
  logic [7:0]            addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  exc_valid;
  logic [4:0]            exc_code;
  logic [31:0]           exc_pc;
  logic                  exc_bd;
  logic                  exc_badva_we;
  logic [31:0]           exc_badva;
  logic                  eret;
  logic                  int_req;
  logic [31:0]           epc_o;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;

  modport master (
    output we, addr, wdata, hw_int, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badva_we, exc_badva, eret,
    input  rdata, int_req, epc_o, status_o, cause_o
  );

  modport slave (
    input  we, addr, wdata, hw_int, exc_valid, exc_code, exc_pc, exc_bd,
           exc_badva_we, exc_badva, eret,
    output rdata, int_req, epc_o, status_o, cause_o
  );
endinterface

// File: rtl/cp0_core_param.sv
// rtl/cp0_core_param.sv - MIPS32 CP0 register file with Count prescaler, hw_int syncs, timer flag; option macro CP0_TIMER_IRQ_EN
module cp0_core_param #(
  parameter int unsigned COUNT_DIV    = 2,
  parameter int unsigned NUM_HW_INT   = 6,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input logic            clk,
  input logic            rst,
  cp0_core_param_if.slave bus
);
  localparam int unsigned    PW           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST   = PW'(COUNT_DIV - 1);
  localparam logic [31:0]    STATUS_WMASK = 32'h0000_FF03;
  localparam logic [7:0]     A_BADVA      = 8'h40;
  localparam logic [7:0]     A_COUNT      = 8'h48;
  localparam logic [7:0]     A_COMPARE    = 8'h58;
  localparam logic [7:0]     A_STATUS     = 8'h60;
  localparam logic [7:0]     A_CAUSE      = 8'h68;
  localparam logic [7:0]     A_EPC        = 8'h70;
  localparam logic [7:0]     A_PRID       = 8'h78;

  logic [31:0]           count_q, count_d, compare_q, compare_d;
  logic [31:0]           epc_q, epc_d, badva_q, badva_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d, ie_q, ie_d;
  logic [1:0]            swip_q, swip_d;
  logic                  ti_q, ti_d, bd_q, bd_d;
  logic [4:0]            exccode_q, exccode_d;
  logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_HW_INT-1:0] sync_d [SYNC_STAGES];

  logic        tick;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic [31:0] status_cur, cause_cur, status_wr, cause_wr;

  // Write decode, interrupt-pending vector and architecturally visible Status/Cause
  always_comb begin
    wr_count   = bus.we && (bus.addr == A_COUNT);
    wr_compare = bus.we && (bus.addr == A_COMPARE);
    wr_status  = bus.we && (bus.addr == A_STATUS);
    wr_cause   = bus.we && (bus.addr == A_CAUSE);
    wr_epc     = bus.we && (bus.addr == A_EPC);
    tick       = (presc_q == PRESC_LAST);
    hw_ip      = 6'(sync_q[SYNC_STAGES-1]);
`ifdef CP0_TIMER_IRQ_EN
    ip         = {hw_ip[5] | ti_q, hw_ip[4:0], swip_q};
`else
    ip         = {hw_ip, swip_q};
`endif
    status_cur = (STATUS_RESET & ~STATUS_WMASK) | {16'h0, im_q, 6'h0, exl_q, ie_q};
    cause_cur  = {bd_q, ti_q, 14'h0, ip, 1'b0, exccode_q, 2'b00};
    status_wr  = (status_cur & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
    cause_wr   = {cause_cur[31:10], bus.wdata[9:8], cause_cur[7:0]};
  end

  // MFC0 read mux; a same-cycle MTC0 to the read address returns the merged value
  always_comb begin
    bus.rdata = 32'h0;
    case (bus.addr)
      A_BADVA:   bus.rdata = badva_q;
      A_COUNT:   bus.rdata = bus.we ? bus.wdata : count_q;
      A_COMPARE: bus.rdata = bus.we ? bus.wdata : compare_q;
      A_STATUS:  bus.rdata = bus.we ? status_wr : status_cur;
      A_CAUSE:   bus.rdata = bus.we ? cause_wr : cause_cur;
      A_EPC:     bus.rdata = bus.we ? bus.wdata : epc_q;
      A_PRID:    bus.rdata = PRID_VALUE;
      default:   bus.rdata = 32'h0;
    endcase
  end

  // Next state: MTC0 first, then ERET, then exception commit so the exception wins
  always_comb begin
    count_d   = count_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    swip_d    = swip_q;
    epc_d     = epc_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    badva_d   = badva_q;
    sync_d[0] = bus.hw_int;
    for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];

    if (wr_count) begin
      count_d = bus.wdata;
      presc_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_d = count_q + 32'd1;
        if ((count_q + 32'd1) == compare_q) ti_d = 1'b1;
      end
    end
    if (wr_compare) begin
      compare_d = bus.wdata;
      ti_d      = 1'b0;
    end
    if (wr_status) begin
      im_d  = bus.wdata[15:8];
      exl_d = bus.wdata[1];
      ie_d  = bus.wdata[0];
    end
    if (wr_cause) swip_d = bus.wdata[9:8];
    if (wr_epc) epc_d = bus.wdata;
    if (bus.eret) exl_d = 1'b0;
    if (bus.exc_valid) begin
      exl_d     = 1'b1;
      exccode_d = bus.exc_code;
      if (!exl_q) begin
        epc_d = bus.exc_pc;
        bd_d  = bus.exc_bd;
      end
      if (bus.exc_badva_we) badva_d = bus.exc_badva;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'h0;
      presc_q   <= '0;
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
      im_q      <= STATUS_RESET[15:8];
      exl_q     <= STATUS_RESET[1];
      ie_q      <= STATUS_RESET[0];
      swip_q    <= 2'b00;
      epc_q     <= 32'h0;
      bd_q      <= 1'b0;
      exccode_q <= 5'h0;
      badva_q   <= 32'h0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      presc_q   <= presc_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      swip_q    <= swip_d;
      epc_q     <= epc_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      badva_q   <= badva_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
    end
  end

  assign bus.int_req  = ie_q & ~exl_q & |(ip & im_q);
  assign bus.epc_o    = epc_q;
  assign bus.status_o = status_cur;
  assign bus.cause_o  = cause_cur;
endmodule

// File: tb/tb_cp0_core_param.sv
// tb/tb_cp0_core_param.sv - directed-vector bench for cp0_core_param
module tb_cp0_core_param;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] rd;

  cp0_core_param_if #(.NUM_HW_INT(6)) bus ();

  cp0_core_param dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step(1);
    bus.we = 1'b0; bus.addr = 8'h0; bus.wdata = 32'h0;
  endtask

  task automatic mfc0(input logic [7:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
    bus.addr = 8'h0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.we = 1'b0; bus.addr = 8'h0; bus.wdata = 32'h0; bus.hw_int = '0;
    bus.exc_valid = 1'b0; bus.exc_code = 5'h0; bus.exc_pc = 32'h0; bus.exc_bd = 1'b0;
    bus.exc_badva_we = 1'b0; bus.exc_badva = 32'h0; bus.eret = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    checks++; if (bus.status_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h exp %h", bus.status_o, 32'h0040_0000); end
    checks++; if (bus.cause_o !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp %h", bus.cause_o, 32'h0); end
    checks++; if (bus.epc_o !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp %h", bus.epc_o, 32'h0); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got %b exp 0", bus.int_req); end
    mfc0(8'h48, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp %h", rd, 32'h0); end
    rst = 1'b0;
  endtask

  task automatic test_count;
    do_reset();
    step(10);
    mfc0(8'h48, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL count_after_10 got %h exp %h", rd, 32'd5); end
    mtc0(8'h58, 32'h0000_0020);
    bus.we = 1'b1; bus.addr = 8'h48; bus.wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_bypass got %h exp %h", bus.rdata, 32'hFFFF_FFFF); end
    step(1);
    bus.we = 1'b0; bus.addr = 8'h0; bus.wdata = 32'h0;
    step(2);
    mfc0(8'h48, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL count_wrap got %h exp %h", rd, 32'h0); end
    checks++; if (bus.cause_o[30] !== 1'b0) begin errors++; $display("FAIL count_wrap_ti got %b exp 0", bus.cause_o[30]); end
  endtask

  task automatic test_timer_irq;
    logic exp_irq;
`ifdef CP0_TIMER_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    do_reset();
    mtc0(8'h58, 32'h0000_0010);
    mtc0(8'h60, 32'h0000_8001);
    checks++; if (bus.status_o !== 32'h0040_8001) begin errors++; $display("FAIL timer_status got %h exp %h", bus.status_o, 32'h0040_8001); end
    mtc0(8'h48, 32'h0000_000E);
    step(3);
    checks++; if (bus.cause_o[30] !== 1'b0) begin errors++; $display("FAIL ti_early got %b exp 0", bus.cause_o[30]); end
    step(1);
    checks++; if (bus.cause_o[30] !== 1'b1) begin errors++; $display("FAIL ti_set got %b exp 1", bus.cause_o[30]); end
    checks++; if (bus.int_req !== exp_irq) begin errors++; $display("FAIL ti_int_req got %b exp %b", bus.int_req, exp_irq); end
    mfc0(8'h48, rd);
    checks++; if (rd !== 32'h10) begin errors++; $display("FAIL ti_count got %h exp %h", rd, 32'h10); end
    mtc0(8'h58, 32'h0000_0040);
    checks++; if (bus.cause_o[30] !== 1'b0) begin errors++; $display("FAIL ti_clear got %b exp 0", bus.cause_o[30]); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ti_clear_int_req got %b exp 0", bus.int_req); end
  endtask

  task automatic test_hw_int;
    do_reset();
    mtc0(8'h60, 32'h0000_0401);
    bus.hw_int = 6'b000001;
    step(1);
    checks++; if (bus.cause_o[10] !== 1'b0) begin errors++; $display("FAIL hw_sync_early got %b exp 0", bus.cause_o[10]); end
    step(1);
    checks++; if (bus.cause_o[15:8] !== 8'h04) begin errors++; $display("FAIL hw_ip got %h exp %h", bus.cause_o[15:8], 8'h04); end
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL hw_int_req got %b exp 1", bus.int_req); end
    mtc0(8'h60, 32'h0000_0403);
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL hw_exl_mask got %b exp 0", bus.int_req); end
    mtc0(8'h68, 32'hFFFF_FFFF);
    checks++; if (bus.cause_o !== 32'h0000_0700) begin errors++; $display("FAIL cause_write got %h exp %h", bus.cause_o, 32'h0000_0700); end
    bus.hw_int = '0;
  endtask

  task automatic test_exception;
    do_reset();
    bus.exc_valid = 1'b1; bus.exc_pc = 32'hBFC0_0100; bus.exc_code = 5'd4;
    bus.exc_bd = 1'b0; bus.exc_badva_we = 1'b1; bus.exc_badva = 32'h0000_1234;
    step(1);
    bus.exc_pc = 32'h8000_0180; bus.exc_code = 5'd5; bus.exc_bd = 1'b1;
    bus.exc_badva_we = 1'b0; bus.exc_badva = 32'h0000_5678;
    bus.exc_valid = 1'b0;
    checks++; if (bus.epc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL exc_epc got %h exp %h", bus.epc_o, 32'hBFC0_0100); end
    checks++; if (bus.cause_o !== 32'h0000_0010) begin errors++; $display("FAIL exc_cause got %h exp %h", bus.cause_o, 32'h0000_0010); end
    checks++; if (bus.status_o !== 32'h0040_0002) begin errors++; $display("FAIL exc_exl got %h exp %h", bus.status_o, 32'h0040_0002); end
    mfc0(8'h40, rd);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL exc_badva got %h exp %h", rd, 32'h0000_1234); end
    bus.exc_valid = 1'b1;
    step(1);
    bus.exc_valid = 1'b0;
    checks++; if (bus.epc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL nested_epc got %h exp %h", bus.epc_o, 32'hBFC0_0100); end
    checks++; if (bus.cause_o !== 32'h0000_0014) begin errors++; $display("FAIL nested_cause got %h exp %h", bus.cause_o, 32'h0000_0014); end
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
    checks++; if (bus.status_o !== 32'h0040_0000) begin errors++; $display("FAIL eret_exl got %h exp %h", bus.status_o, 32'h0040_0000); end
  endtask

  task automatic test_priority;
    do_reset();
    bus.exc_valid = 1'b1; bus.exc_pc = 32'h0000_0400; bus.exc_code = 5'd8; bus.eret = 1'b1;
    mtc0(8'h60, 32'h0000_0000);
    bus.exc_valid = 1'b0; bus.eret = 1'b0;
    checks++; if (bus.status_o !== 32'h0040_0002) begin errors++; $display("FAIL prio_exl got %h exp %h", bus.status_o, 32'h0040_0002); end
    bus.we = 1'b1; bus.addr = 8'h78; bus.wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.rdata !== 32'h0001_8000) begin errors++; $display("FAIL prid_bypass got %h exp %h", bus.rdata, 32'h0001_8000); end
    step(1);
    bus.we = 1'b0; bus.wdata = 32'h0;
    mfc0(8'h78, rd);
    checks++; if (rd !== 32'h0001_8000) begin errors++; $display("FAIL prid_ro got %h exp %h", rd, 32'h0001_8000); end
    mfc0(8'h50, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp %h", rd, 32'h0); end
  endtask

  task automatic test_reset_override;
    do_reset();
    mtc0(8'h60, 32'h0000_FF01);
    rst = 1'b1; bus.exc_valid = 1'b1; bus.exc_pc = 32'h1111_2222;
    step(1);
    rst = 1'b0; bus.exc_valid = 1'b0;
    checks++; if (bus.epc_o !== 32'h0) begin errors++; $display("FAIL rst_override_epc got %h exp %h", bus.epc_o, 32'h0); end
    checks++; if (bus.status_o !== 32'h0040_0000) begin errors++; $display("FAIL rst_override_status got %h exp %h", bus.status_o, 32'h0040_0000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    test_reset();
    test_count();
    test_timer_irq();
    test_hw_int();
    test_exception();
    test_priority();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
